// File: rtl/axi_rd_byte_packer_if.sv
// Beat input and SRAM write bundle for the read-path byte packer.
// The slave modport is the packer; the master modport is the read controller/SRAM side.
interface axi_rd_byte_packer_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 32,
  parameter int BYTE_CNT_WIDTH  = 17
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                       pk_start_i;
  logic [SRAM_ADDR_WIDTH-1:0] pk_base_addr_i;
  logic                       pk_busy_i;
  logic [STRB_WIDTH-1:0]      pk_byte_valid_i;
  logic [DATA_WIDTH-1:0]      pk_data_i;

  logic                       pk_sram_we_o;
  logic [SRAM_ADDR_WIDTH-1:0] pk_sram_addr_o;
  logic [DATA_WIDTH-1:0]      pk_sram_wdata_o;
  logic [STRB_WIDTH-1:0]      pk_sram_wstrb_o;
  logic                       pk_done_o;
  logic [BYTE_CNT_WIDTH-1:0]  pk_byte_cnt_o;
  logic                       pk_error_o;

  modport master (
    output pk_start_i, pk_base_addr_i, pk_busy_i, pk_byte_valid_i, pk_data_i,
    input  pk_sram_we_o, pk_sram_addr_o, pk_sram_wdata_o, pk_sram_wstrb_o,
           pk_done_o, pk_byte_cnt_o, pk_error_o
  );

  modport slave (
    input  pk_start_i, pk_base_addr_i, pk_busy_i, pk_byte_valid_i, pk_data_i,
    output pk_sram_we_o, pk_sram_addr_o, pk_sram_wdata_o, pk_sram_wstrb_o,
           pk_done_o, pk_byte_cnt_o, pk_error_o
  );
endinterface

// File: rtl/axi_rd_byte_packer.sv
// Repacks byte-strobed read beats into dense word-aligned SRAM writes,
// flushing any residual bytes as a strobed partial write when busy drops.
module axi_rd_byte_packer #(
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 32,
  parameter int BYTE_CNT_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_rd_byte_packer_if.slave   pk
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int RES_W      = $clog2(STRB_WIDTH);
  localparam int CNT_W      = RES_W + 1;
  localparam int BC_W1      = BYTE_CNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_next;

  logic                       busy_q;
  logic [DATA_WIDTH-1:0]      res_data, res_data_next;
  logic [RES_W-1:0]           res_n, res_n_next;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr;
  logic                       error, err_next;

  logic                       we;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [STRB_WIDTH-1:0]      wstrb;
  logic                       done;
  logic [BYTE_CNT_WIDTH-1:0]  byte_cnt;

  logic [STRB_WIDTH-1:0]      mask;
  logic [STRB_WIDTH-1:0]      span;
  logic [RES_W-1:0]           lo, hi;
  logic                       found;
  logic [CNT_W-1:0]           n;
  logic [CNT_W-1:0]           total;
  logic                       beat_ok, beat_bad, flush_req;

  logic [DATA_WIDTH-1:0]      beat_masked, beat_shifted;
  logic [2*DATA_WIDTH-1:0]    work;
  logic [STRB_WIDTH-1:0]      flush_strb;

  logic                       wr_fire;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [STRB_WIDTH-1:0]      wr_strb;
  logic [CNT_W-1:0]           wr_bytes;
  logic [BC_W1-1:0]           cnt_sum;
  logic [BYTE_CNT_WIDTH-1:0]  cnt_sat;

  assign mask = pk.pk_byte_valid_i;

  // Contiguous means the mask equals the solid run of ones from its lowest to highest set bit.
  always_comb begin
    lo    = '0;
    hi    = '0;
    found = 1'b0;
    span  = '0;
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      if (mask[i]) begin
        hi = RES_W'(i);
        if (!found) lo = RES_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      span[i] = (i >= 32'(lo)) && (i <= 32'(hi));
    end
  end

  assign beat_ok   = (state == RUN) && found && (mask == span);
  assign beat_bad  = (state == RUN) && found && (mask != span);
  assign flush_req = (state == RUN) && busy_q && !pk.pk_busy_i;

  assign n     = {1'b0, hi} - {1'b0, lo} + CNT_W'(1);
  assign total = {1'b0, res_n} + n;

  always_comb begin
    beat_masked = '0;
    flush_strb  = '0;
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      beat_masked[8*i +: 8] = mask[i] ? pk.pk_data_i[8*i +: 8] : 8'h00;
      flush_strb[i]         = (i < 32'(res_n));
    end
  end

  // Bytes above res_n in res_data are kept zero, so OR-ing in the shifted beat is safe.
  assign beat_shifted = beat_masked >> {lo, 3'b000};
  assign work = {{DATA_WIDTH{1'b0}}, res_data}
              | ({{DATA_WIDTH{1'b0}}, beat_shifted} << {res_n, 3'b000});

  always_comb begin
    wr_fire       = 1'b0;
    wr_data       = '0;
    wr_strb       = '0;
    wr_bytes      = '0;
    res_n_next    = res_n;
    res_data_next = res_data;
    err_next      = error;
    if (state == RUN) begin
      if (beat_bad) begin
        err_next = 1'b1;
      end else if (beat_ok) begin
        if (total >= CNT_W'(STRB_WIDTH)) begin
          wr_fire       = 1'b1;
          wr_data       = work[DATA_WIDTH-1:0];
          wr_strb       = '1;
          wr_bytes      = CNT_W'(STRB_WIDTH);
          res_data_next = work[2*DATA_WIDTH-1:DATA_WIDTH];
          res_n_next    = RES_W'(total - CNT_W'(STRB_WIDTH));
        end else begin
          res_data_next = work[DATA_WIDTH-1:0];
          res_n_next    = total[RES_W-1:0];
        end
      end
    end else if (state == FLUSH && res_n != '0) begin
      wr_fire       = 1'b1;
      wr_data       = res_data;
      wr_strb       = flush_strb;
      wr_bytes      = {1'b0, res_n};
      res_data_next = '0;
      res_n_next    = '0;
    end
  end

  assign cnt_sum = {1'b0, byte_cnt} + BC_W1'(wr_bytes);
  assign cnt_sat = cnt_sum[BC_W1-1] ? '1 : cnt_sum[BYTE_CNT_WIDTH-1:0];

  always_comb begin
    state_next = state;
    if (pk.pk_start_i) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (flush_req) state_next = FLUSH;
        FLUSH:   state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      res_data  <= '0;
      res_n     <= '0;
      wr_addr   <= '0;
      error     <= 1'b0;
      we        <= 1'b0;
      sram_addr <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      done      <= 1'b0;
      byte_cnt  <= '0;
    end else if (pk.pk_start_i) begin
      busy_q    <= pk.pk_busy_i;
      res_data  <= '0;
      res_n     <= '0;
      wr_addr   <= pk.pk_base_addr_i;
      sram_addr <= pk.pk_base_addr_i;
      error     <= 1'b0;
      we        <= 1'b0;
      done      <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      busy_q   <= pk.pk_busy_i;
      res_data <= res_data_next;
      res_n    <= res_n_next;
      error    <= err_next;
      we       <= wr_fire;
      done     <= (state == FLUSH);
      if (wr_fire) begin
        wdata     <= wr_data;
        wstrb     <= wr_strb;
        sram_addr <= wr_addr;
        wr_addr   <= wr_addr + SRAM_ADDR_WIDTH'(1);
        byte_cnt  <= cnt_sat;
      end
    end
  end

  assign pk.pk_sram_we_o    = we;
  assign pk.pk_sram_addr_o  = sram_addr;
  assign pk.pk_sram_wdata_o = wdata;
  assign pk.pk_sram_wstrb_o = wstrb;
  assign pk.pk_done_o       = done;
  assign pk.pk_byte_cnt_o   = byte_cnt;
  assign pk.pk_error_o      = error;
endmodule

// File: tb/tb_axi_rd_byte_packer.sv
// Scoreboard bench for axi_rd_byte_packer: directed beats queue expected SRAM writes
// and done-time byte counts; a negedge monitor pops and compares them.
module tb_axi_rd_byte_packer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_byte_packer_if #(.DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .BYTE_CNT_WIDTH(CW)) bus ();

  axi_rd_byte_packer #(.DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .BYTE_CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .pk  (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_cnt[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t mon_e;
  int  mon_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pk_sram_we_o) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h strb 0x%0h, expected no write",
                   bus.pk_sram_addr_o, bus.pk_sram_wdata_o, bus.pk_sram_wstrb_o);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", 64'(bus.pk_sram_addr_o), 64'(mon_e.addr));
          check("wr_data", 64'(bus.pk_sram_wdata_o), 64'(mon_e.data));
          check("wr_strb", 64'(bus.pk_sram_wstrb_o), 64'(mon_e.strb));
        end
      end
      if (bus.pk_done_o) begin
        if (exp_cnt.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 byte_cnt %0d, expected no done", bus.pk_byte_cnt_o);
        end else begin
          mon_c = exp_cnt.pop_front();
          check("done_byte_cnt", 64'(bus.pk_byte_cnt_o), 64'(mon_c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    bus.pk_start_i      = 1'b1;
    bus.pk_base_addr_i  = base;
    bus.pk_busy_i       = 1'b1;
    bus.pk_byte_valid_i = 4'h0;
    tick();
    bus.pk_start_i      = 1'b0;
  endtask

  task automatic beat(input logic [3:0] m, input logic [31:0] d, input logic busy);
    bus.pk_byte_valid_i = m;
    bus.pk_data_i       = d;
    bus.pk_busy_i       = busy;
    tick();
    bus.pk_byte_valid_i = 4'h0;
  endtask

  // Entered just after the edge that saw busy low; counts edges until done is visible.
  task automatic wait_done(input string name, input int exp_lat);
    int c;
    c = 1;
    while (!bus.pk_done_o && c < 10) begin
      tick();
      c++;
    end
    check(name, 64'(c), 64'(exp_lat));
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.strb = s;
    exp_wr.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(bus.pk_sram_we_o),    64'd0);
    check({tag, "_addr"},  64'(bus.pk_sram_addr_o),  64'd0);
    check({tag, "_wdata"}, 64'(bus.pk_sram_wdata_o), 64'd0);
    check({tag, "_wstrb"}, 64'(bus.pk_sram_wstrb_o), 64'd0);
    check({tag, "_done"},  64'(bus.pk_done_o),       64'd0);
    check({tag, "_cnt"},   64'(bus.pk_byte_cnt_o),   64'd0);
    check({tag, "_error"}, 64'(bus.pk_error_o),      64'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.pk_start_i      = 1'b0;
    bus.pk_base_addr_i  = '0;
    bus.pk_busy_i       = 1'b0;
    bus.pk_byte_valid_i = '0;
    bus.pk_data_i       = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: aligned beats, no flush write
    push_wr(32'h10, 32'h03020100, 4'hF);
    push_wr(32'h11, 32'h07060504, 4'hF);
    exp_cnt.push_back(8);
    do_start(32'h10);
    beat(4'hF, 32'h03020100, 1'b1);
    beat(4'hF, 32'h07060504, 1'b1);
    beat(4'h0, 32'h0, 1'b0);
    wait_done("t1_done_latency", 2);
    tick();
    tick();
    check("t1_addr_hold", 64'(bus.pk_sram_addr_o), 64'h11);
    check("t1_cnt_hold",  64'(bus.pk_byte_cnt_o),  64'd8);

    // 2: misaligned head and tail
    push_wr(32'h10, 32'h05040302, 4'hF);
    push_wr(32'h11, 32'h09080706, 4'hF);
    exp_cnt.push_back(8);
    do_start(32'h10);
    beat(4'hC, 32'h0302DEAD, 1'b1);
    beat(4'hF, 32'h07060504, 1'b1);
    beat(4'h3, 32'hCAFE0908, 1'b1);
    beat(4'h0, 32'h0, 1'b0);
    wait_done("t2_done_latency", 2);
    tick();

    // 3: lone partial beat flushed with strobe
    push_wr(32'h10, 32'h0000BBAA, 4'h3);
    exp_cnt.push_back(2);
    do_start(32'h10);
    beat(4'hC, 32'hBBAA1234, 1'b1);
    beat(4'h0, 32'h0, 1'b0);
    wait_done("t3_done_latency", 2);
    tick();

    // 4: beat in the same cycle busy falls
    push_wr(32'h10, 32'h04030201, 4'hF);
    push_wr(32'h11, 32'h00070605, 4'h7);
    exp_cnt.push_back(7);
    do_start(32'h10);
    beat(4'hE, 32'h030201FF, 1'b1);
    beat(4'hF, 32'h07060504, 1'b0);
    wait_done("t4_done_latency", 2);
    tick();

    // 5: non-contiguous mask sets sticky error
    exp_cnt.push_back(0);
    do_start(32'h10);
    beat(4'h5, 32'h11223344, 1'b1);
    check("t5_error_set", 64'(bus.pk_error_o), 64'd1);
    beat(4'h0, 32'h0, 1'b1);
    check("t5_error_held", 64'(bus.pk_error_o), 64'd1);
    beat(4'h0, 32'h0, 1'b0);
    wait_done("t5_done_latency", 2);
    check("t5_error_after_done", 64'(bus.pk_error_o), 64'd1);
    do_start(32'h20);
    check("t5_error_cleared", 64'(bus.pk_error_o), 64'd0);
    check("t5_addr_base",     64'(bus.pk_sram_addr_o), 64'h20);

    // 6: restart discards residual; reset mid-run clears everything
    do_start(32'h10);
    beat(4'h3, 32'h0000BEEF, 1'b1);
    do_start(32'h40);
    check("t6_addr_restart", 64'(bus.pk_sram_addr_o), 64'h40);
    check("t6_cnt_restart",  64'(bus.pk_byte_cnt_o),  64'd0);
    push_wr(32'h40, 32'h44332211, 4'hF);
    beat(4'hF, 32'h44332211, 1'b1);
    check("t6_cnt_after_write", 64'(bus.pk_byte_cnt_o), 64'd4);
    beat(4'h3, 32'hAAAA5566, 1'b1);
    rst = 1'b1;
    tick();
    check_all_zero("t6_midrun_reset");
    rst = 1'b0;
    beat(4'h0, 32'h0, 1'b0);
    beat(4'hF, 32'h99887766, 1'b0);
    tick();
    tick();
    check("t6_idle_no_write", 64'(bus.pk_sram_we_o), 64'd0);

    // 7: address wraps past all ones
    push_wr(32'hFFFF_FFFF, 32'hA3A2A1A0, 4'hF);
    push_wr(32'h0000_0000, 32'hB3B2B1B0, 4'hF);
    exp_cnt.push_back(8);
    do_start(32'hFFFF_FFFF);
    beat(4'hF, 32'hA3A2A1A0, 1'b1);
    beat(4'hF, 32'hB3B2B1B0, 1'b1);
    beat(4'h0, 32'h0, 1'b0);
    wait_done("t7_done_latency", 2);
    tick();
    tick();

    check("pending_writes", 64'(exp_wr.size()),  64'd0);
    check("pending_dones",  64'(exp_cnt.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
